// File: rtl/ifu_fetch_pkg.sv
// ============================================================================
// Module  : ifu_fetch_pkg
// Brief   : Shared widths, FSM encodings and constants for the fetch unit.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package ifu_fetch_pkg;

    localparam int CPU_WIDTH = 32;
    localparam int INS_WIDTH = 32;

    localparam logic [1:0] IFU_ST_REQ  = 2'd0;
    localparam logic [1:0] IFU_ST_WAIT = 2'd1;
    localparam logic [1:0] IFU_ST_HOLD = 2'd2;

    localparam logic [CPU_WIDTH-1:0] DEFAULT_RESET_PC = 32'h8000_0000;
    localparam logic [INS_WIDTH-1:0] INST_NOP         = 32'h0000_0013;

    function automatic logic [CPU_WIDTH-1:0] align_word(input logic [CPU_WIDTH-1:0] addr);
        return {addr[CPU_WIDTH-1:2], 2'b00};
    endfunction

endpackage

`default_nettype wire

// File: rtl/ifu_pc_gen.sv
// ============================================================================
// Module  : ifu_pc_gen
// Brief   : Architectural PC register with hold / +4 / redirect next-PC mux.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ifu_pc_gen
    import ifu_fetch_pkg::*;
#(
    parameter logic [CPU_WIDTH-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_advance,
    input  logic                 i_redirect,
    input  logic [CPU_WIDTH-1:0] i_redirect_pc,
    output logic [CPU_WIDTH-1:0] o_pc
);

    logic [CPU_WIDTH-1:0] pc_q;
    logic [CPU_WIDTH-1:0] pc_d;

    // Redirect outranks sequential advance; +4 wraps naturally at 2^32.
    always_comb begin
        pc_d = pc_q;
        if (i_redirect) begin
            pc_d = align_word(i_redirect_pc);
        end else if (i_advance) begin
            pc_d = pc_q + 32'd4;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            pc_q <= align_word(RESET_PC);
        end else begin
            pc_q <= pc_d;
        end
    end

    assign o_pc = pc_q;

endmodule

`default_nettype wire

// File: rtl/ifu_fetch.sv
// ============================================================================
// Module  : ifu_fetch
// Brief   : Single-outstanding instruction fetch unit feeding the decoder.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter logic [CPU_WIDTH-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    output logic                 o_imem_req_valid,
    input  logic                 i_imem_req_ready,
    output logic [CPU_WIDTH-1:0] o_imem_addr,
    input  logic                 i_imem_rsp_valid,
    input  logic [INS_WIDTH-1:0] i_imem_rdata,
    output logic                 o_ifu_valid,
    input  logic                 i_idu_ready,
    output logic [CPU_WIDTH-1:0] o_ifu_pc,
    output logic [INS_WIDTH-1:0] o_ifu_inst,
    input  logic                 i_redirect,
    input  logic [CPU_WIDTH-1:0] i_redirect_pc
);

    logic [1:0]           state_q;
    logic [1:0]           state_d;
    logic                 discard_q;
    logic                 discard_d;
    logic [INS_WIDTH-1:0] inst_q;
    logic [INS_WIDTH-1:0] inst_d;
    logic                 w_advance;
    logic                 w_req_hs;
    logic [CPU_WIDTH-1:0] w_pc;

    ifu_pc_gen #(
        .RESET_PC (RESET_PC)
    ) u_pc_gen (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_advance     (w_advance),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .o_pc          (w_pc)
    );

    // Gating with reset keeps the request low while reset is held.
    assign o_imem_req_valid = (state_q == IFU_ST_REQ) && i_rst;
    assign w_req_hs         = o_imem_req_valid && i_imem_req_ready;
    assign o_imem_addr      = w_pc;

    // A redirect in HOLD squashes the presented instruction in the same cycle.
    assign o_ifu_valid = (state_q == IFU_ST_HOLD) && !i_redirect;
    assign o_ifu_pc    = w_pc;
    assign o_ifu_inst  = inst_q;

    always_comb begin
        state_d   = state_q;
        discard_d = discard_q;
        inst_d    = inst_q;
        w_advance = 1'b0;
        case (state_q)
            IFU_ST_REQ: begin
                if (w_req_hs) begin
                    state_d   = IFU_ST_WAIT;
                    discard_d = i_redirect;
                end
            end
            IFU_ST_WAIT: begin
                if (i_imem_rsp_valid) begin
                    discard_d = 1'b0;
                    if (i_redirect || discard_q) begin
                        state_d = IFU_ST_REQ;
                    end else begin
                        inst_d  = i_imem_rdata;
                        state_d = IFU_ST_HOLD;
                    end
                end else if (i_redirect) begin
                    discard_d = 1'b1;
                end
            end
            IFU_ST_HOLD: begin
                if (i_redirect) begin
                    state_d = IFU_ST_REQ;
                end else if (i_idu_ready) begin
                    state_d   = IFU_ST_REQ;
                    w_advance = 1'b1;
                end
            end
            default: begin
                state_d = IFU_ST_REQ;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q   <= IFU_ST_REQ;
            discard_q <= 1'b0;
            inst_q    <= INST_NOP;
        end else begin
            state_q   <= state_d;
            discard_q <= discard_d;
            inst_q    <= inst_d;
        end
    end

endmodule

`default_nettype wire

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction fetch unit; the producer end of the decoder's input interface. Drives o_ifu_pc and o_ifu_inst into the decode stage.
- Holds the architectural PC and fetches 32-bit words from instruction memory over a request/response handshake.
- Presents each fetched instruction to decode with valid/ready flow control.
- Accepts PC redirects from jal/jalr/branch resolution and squashes wrong-path fetches.

Parameters:
- RESET_PC, 32'h8000_0000, PC loaded on reset; bits [1:0] must be 0.
- (Widths use `CPU_WIDTH = 32 and `INS_WIDTH = 32 from defines.v.)

Ports:
- i_clk  in  1  clock; all state updates on posedge.
- i_rst  in  1  reset; asynchronous, active-low.
- o_imem_req_valid  out  1  fetch request valid.
- i_imem_req_ready  in  1  memory accepts request.
- o_imem_addr  out  32  fetch address, word aligned.
- i_imem_rsp_valid  in  1  response data valid; one response per accepted request, in order.
- i_imem_rdata  in  32  fetched instruction word.
- o_ifu_valid  out  1  instruction valid toward decode.
- i_idu_ready  in  1  decode consumes instruction.
- o_ifu_pc  out  32  PC of the presented instruction.
- o_ifu_inst  out  32  presented instruction.
- i_redirect  in  1  PC redirect, single-cycle pulse.
- i_redirect_pc  in  32  redirect target; bits [1:0] forced to 0 internally.

Behaviour:
- Reset (i_rst=0, asynchronous): state=REQ, pc=RESET_PC, discard=0, inst_q=32'h0000_0013 (nop).
  - Outputs during reset: o_imem_req_valid=0, o_ifu_valid=0, o_imem_addr=RESET_PC.
  - First request is asserted in the first cycle after reset deasserts.
- State machine:
  - REQ: o_imem_req_valid=1, o_imem_addr=pc.
    - req_valid & req_ready -> WAIT.
    - Address changes only on redirect.
  - WAIT: o_imem_req_valid=0.
    - On rsp_valid with discard=0: latch inst_q=rdata -> HOLD.
    - On rsp_valid with discard=1: drop data, clear discard -> REQ.
  - HOLD: o_ifu_valid=1; o_ifu_pc=pc and o_ifu_inst=inst_q held stable.
    - On o_ifu_valid & i_idu_ready: pc<=pc+4 -> REQ.
- Latency: minimum 3 cycles per instruction (REQ, WAIT, HOLD) with zero-wait memory. No prefetch; at most one request outstanding.
- Redirect handling (priority over all other transitions):
  - REQ, no handshake this cycle: pc<=target, stay in REQ; next cycle's address = target.
  - REQ with handshake in the same cycle: pc<=target, discard<=1 -> WAIT.
  - WAIT without rsp_valid: pc<=target, discard<=1, stay in WAIT.
  - WAIT with rsp_valid in the same cycle: drop data, pc<=target, discard<=0 -> REQ.
  - HOLD: held instruction is squashed, pc<=target -> REQ.
    - o_ifu_valid = (state==HOLD) & ~i_redirect (combinational mask), so decode never consumes the squashed instruction.
    - i_idu_ready is ignored in that cycle.
- Back-to-back redirects: the last one wins. discard stays 1 until the single outstanding response returns.
- PC arithmetic is 32-bit, wraps modulo 2^32 (32'hFFFF_FFFC+4 = 0).
- Reset mid-transaction: all state is cleared. A response that arrives after reset with no request outstanding is ignored (rsp_valid is only sampled in WAIT).
- rsp_valid outside WAIT: ignored.

Decomposition:
- defines.v gets:
  - IFU_ST_REQ/WAIT/HOLD 2-bit state encodings.
  - `RESET_PC default.
  - `INST_NOP = 32'h0000_0013.
- Sub-module ifu_pc_gen: PC register, next-PC mux (hold / +4 / redirect), and alignment masking.
- The FSM and inst_q stay in ifu_fetch.

Test Plan:
- Reset release, zero-wait memory returning 32'h00100093 at 0x80000000 and 32'h00208113 at 0x80000004; idu_ready=1:
  - First request addr=0x80000000 in cycle 1.
  - o_ifu_valid in cycle 3 with pc=0x80000000, inst=00100093.
  - Next instruction presented at pc=0x80000004.
- Decode backpressure: idu_ready=0 for 5 cycles in HOLD:
  - o_ifu_valid, pc and inst stable all 5 cycles.
  - No new request issued.
  - Advances one cycle after ready=1.
- Redirect in WAIT to 0x80000100, response returns 2 cycles later:
  - Response dropped, o_ifu_valid stays 0.
  - Next request addr=0x80000100.
- Redirect in HOLD with i_idu_ready=1 in the same cycle, target 0x80000203:
  - o_ifu_valid=0 in that cycle.
  - Next request addr=0x80000200.
- Memory req_ready=0 for 4 cycles, redirect to 0x80000040 in cycle 2:
  - Addr switches to 0x80000040 in cycle 3.
  - Handshake completes with that address.
- Assert i_rst=0 in WAIT, release after 2 cycles:
  - Outputs immediately reset.
  - Request restarts at 0x80000000.
  - A stray rsp_valid during REQ is ignored.
